// File: rtl/mem_request_arbiter_if.sv
// Request/response and RAM-side signals of the memory request arbiter.
// The arbiter connects through the slave modport. The control unit and the
// RAM model connect through the master modport.
interface mem_request_arbiter_if;
  // Control unit requests
  logic        instrread;
  logic [31:0] pcAddrIn;
  logic        memread;
  logic        memwrite;
  logic [31:0] daddr;
  logic [31:0] dstore;
  // Control unit responses
  logic        ihit;
  logic        dhit;
  logic [31:0] instr;
  logic [31:0] dload;
  // Unified RAM port
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;

  modport slave (
    input  instrread, pcAddrIn, memread, memwrite, daddr, dstore,
    input  ram_load, ram_ready,
    output ihit, dhit, instr, dload,
    output ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output instrread, pcAddrIn, memread, memwrite, daddr, dstore,
    output ram_load, ram_ready,
    input  ihit, dhit, instr, dload,
    input  ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// Arbitrates fetch and data requests onto a single-ported unified RAM.
// It serves one access at a time and gives priority to data requests. A burst
// counter makes sure a pending fetch is served after MAX_DBURST data grants.
// A watchdog aborts an access when the RAM does not respond. Every output is
// registered.
module mem_request_arbiter #(
  parameter int MAX_DBURST  = 4,
  parameter int TIMEOUT_CYC = 64   // legal range 2..255
) (
  input  logic                   CLK,
  input  logic                   nRST,
  mem_request_arbiter_if.slave   bus,
  output logic                   timeout_err
);

  localparam int CNT_W = ($clog2(MAX_DBURST + 1) > 3) ? $clog2(MAX_DBURST + 1) : 3;
  localparam logic [CNT_W-1:0] DBURST_MAX = CNT_W'(MAX_DBURST);
  localparam logic [7:0]       WD_LAST    = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {K_I, K_DR, K_DW} kind_t;

  state_t           state;
  kind_t            kind;
  logic [CNT_W-1:0] dburst_cnt;
  logic [7:0]       wd_cnt;

  logic data_req;
  logic data_grant;
  logic fetch_grant;

  // Grant decode for IDLE. Data wins unless a fetch has waited through a full burst.
  assign data_req    = bus.memread | bus.memwrite;
  assign data_grant  = data_req && !(bus.instrread && (dburst_cnt == DBURST_MAX));
  assign fetch_grant = bus.instrread && !data_grant;

  // Access sequencer: grant, RAM handshake with watchdog, one-cycle hit.
  // NOTE: all state and outputs update with non-blocking assignments. Every
  // read inside this block therefore sees the value from before the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      kind          <= K_I;
      dburst_cnt    <= '0;
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
      bus.ihit      <= 1'b0;
      bus.dhit      <= 1'b0;
      bus.instr     <= '0;
      bus.dload     <= '0;
      bus.ram_ren   <= 1'b0;
      bus.ram_wen   <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_store <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_grant) begin
            // A read together with a write is served as a store.
            kind          <= bus.memwrite ? K_DW : K_DR;
            bus.ram_addr  <= bus.daddr & ~32'h3;
            bus.ram_store <= bus.dstore;
            bus.ram_wen   <= bus.memwrite;
            bus.ram_ren   <= ~bus.memwrite;
            wd_cnt        <= '0;
            state         <= ACCESS;
            if (!bus.instrread)
              dburst_cnt <= '0;
            else if (dburst_cnt != DBURST_MAX)
              dburst_cnt <= dburst_cnt + 1'b1;
          end else if (fetch_grant) begin
            kind         <= K_I;
            bus.ram_addr <= bus.pcAddrIn & ~32'h3;
            bus.ram_ren  <= 1'b1;
            bus.ram_wen  <= 1'b0;
            wd_cnt       <= '0;
            dburst_cnt   <= '0;
            state        <= ACCESS;
          end
        end

        ACCESS: begin
          if (bus.ram_ready) begin
            bus.ram_ren <= 1'b0;
            bus.ram_wen <= 1'b0;
            state       <= RESP;
            unique case (kind)
              K_I: begin
                bus.instr <= bus.ram_load;
                bus.ihit  <= 1'b1;
              end
              K_DR: begin
                bus.dload <= bus.ram_load;
                bus.dhit  <= 1'b1;
              end
              default: bus.dhit <= 1'b1;
            endcase
          end else if (wd_cnt == WD_LAST) begin
            // The RAM has not answered. Abort without a hit. The request is
            // still held, so IDLE arbitrates it again.
            bus.ram_ren <= 1'b0;
            bus.ram_wen <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        RESP: begin
          bus.ihit <= 1'b0;
          bus.dhit <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
